// File: rtl/gray_pkg.sv
// Shared gray-code helpers and limits for the gray counter family.
package gray_pkg;

  localparam int GRAY_MAX_WIDTH = 32;

  // Per-edge action chosen by the counter after priority resolution.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_STEP = 2'd2
  } op_e;

  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Narrower codes zero-extend cleanly: each binary bit is the XOR of all gray bits at or above it.
  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] g);
    logic [GRAY_MAX_WIDTH-1:0] b;
    b[GRAY_MAX_WIDTH-1] = g[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational WIDTH-bit gray-to-binary converter used on the counter load path.
module gray2bin_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Reduction per bit keeps the logic flat instead of a rippling chain.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign bin[gi] = ^gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_updown_counter.sv
// WIDTH-bit up/down counter with registered binary and gray outputs, gray-coded load and wrap pulse.
// Define GRAY_CNT_SAT_EN to saturate at the terminal count instead of wrapping (adds the sat output).
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int          WIDTH   = 4,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc,
  output logic             wrap
`ifdef GRAY_CNT_SAT_EN
  ,
  output logic             sat
`endif
);

  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

  logic [WIDTH-1:0] bin_q_reg, bin_next;
  logic [WIDTH-1:0] gray_q_reg, gray_next;
  logic             wrap_reg, wrap_next;
  logic             sat_reg, sat_next;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_step;
  op_e              op;

  gray2bin_n #(
    .WIDTH(WIDTH)
  ) u_load_conv (
    .gray(load_gray),
    .bin (load_bin)
  );

  always_comb begin
    op = OP_HOLD;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
  end

  assign tc       = up ? (&bin_q_reg) : ~(|bin_q_reg);
  assign bin_step = up ? (bin_q_reg + WIDTH'(1)) : (bin_q_reg - WIDTH'(1));

  always_comb begin
    bin_next  = bin_q_reg;
    gray_next = gray_q_reg;
    wrap_next = 1'b0;
    sat_next  = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_next  = load_bin;
        gray_next = load_gray;
      end
      OP_STEP: begin
`ifdef GRAY_CNT_SAT_EN
        // A step at the terminal count is blocked and reported instead of wrapping.
        if (tc) begin
          sat_next = 1'b1;
        end else begin
          bin_next  = bin_step;
          gray_next = bin_step ^ (bin_step >> 1);
        end
`else
        bin_next  = bin_step;
        gray_next = bin_step ^ (bin_step >> 1);
        wrap_next = tc;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q_reg  <= RST_BIN;
      gray_q_reg <= RST_GRAY;
      wrap_reg   <= 1'b0;
      sat_reg    <= 1'b0;
    end else begin
      bin_q_reg  <= bin_next;
      gray_q_reg <= gray_next;
      wrap_reg   <= wrap_next;
      sat_reg    <= sat_next;
    end
  end

  assign bin_q  = bin_q_reg;
  assign gray_q = gray_q_reg;
`ifdef GRAY_CNT_SAT_EN
  assign wrap = 1'b0;
  assign sat  = sat_reg;
  logic unused_wrap;
  assign unused_wrap = wrap_reg;
`else
  assign wrap = wrap_reg;
  logic unused_sat;
  assign unused_sat = sat_reg;
`endif

endmodule

// File: tb/tb_gray_updown_counter.sv
// Directed bench for gray_updown_counter (WIDTH=4) with a per-cycle reference model.
module tb_gray_updown_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_gray = '0;
  logic [W-1:0] bin_q;
  logic [W-1:0] gray_q;
  logic         tc;
  logic         wrap;
`ifdef GRAY_CNT_SAT_EN
  logic         sat;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;

  // Gray code of each 4-bit value, indexed by the binary value.
  logic [W-1:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                   4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                   4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};

  int m_cnt  = 0;
  bit m_wrap = 1'b0;
  bit m_sat  = 1'b0;

  gray_updown_counter #(
    .WIDTH  (W),
    .RST_VAL(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_gray(load_gray),
    .bin_q    (bin_q),
    .gray_q   (gray_q),
    .tc       (tc),
    .wrap     (wrap)
`ifdef GRAY_CNT_SAT_EN
    ,
    .sat      (sat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int gray_index(input logic [W-1:0] g);
    for (int i = 0; i < 16; i++) begin
      if (gray_tab[i] == g) return i;
    end
    return -1;
  endfunction

  always @(posedge rst) begin
    m_cnt  = 0;
    m_wrap = 1'b0;
    m_sat  = 1'b0;
  end

  // Reference model and per-cycle compare.
  always @(posedge clk) begin
    int t;
    cyc++;
    if (rst) begin
      m_cnt  = 0;
      m_wrap = 1'b0;
      m_sat  = 1'b0;
    end else if (load) begin
      m_cnt  = gray_index(load_gray);
      m_wrap = 1'b0;
      m_sat  = 1'b0;
    end else if (en) begin
      t = m_cnt + (up ? 1 : -1);
`ifdef GRAY_CNT_SAT_EN
      m_wrap = 1'b0;
      m_sat  = (t < 0 || t > 15);
      if (!m_sat) m_cnt = t;
`else
      m_wrap = (t < 0 || t > 15);
      m_sat  = 1'b0;
      m_cnt  = (t + 16) % 16;
`endif
    end else begin
      m_wrap = 1'b0;
      m_sat  = 1'b0;
    end
    #1;
    if (chk_en && !rst) begin
      $display("cyc %0d en=%b up=%b load=%b bin=%0d gray=%b tc=%b wrap=%b",
               cyc, en, up, load, bin_q, gray_q, tc, wrap);
      check("model_bin", 32'(bin_q), 32'(m_cnt));
      check("model_gray", 32'(gray_q), 32'(gray_tab[m_cnt]));
      check("model_wrap", 32'(wrap), 32'(m_wrap));
      check("model_tc", 32'(tc), 32'((up && m_cnt == 15) || (!up && m_cnt == 0)));
`ifdef GRAY_CNT_SAT_EN
      check("model_sat", 32'(sat), 32'(m_sat));
`endif
    end
  end

  initial begin
    logic [W-1:0] prev_gray;
    // Reset state, visible without any clock edge.
    #2;
    check("rst_bin", 32'(bin_q), 32'd0);
    check("rst_gray", 32'(gray_q), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);

    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    en = 1'b1;
    up = 1'b1;

    // Full count-up cycle through the wrap.
    prev_gray = gray_q;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #2;
      check("up_gray", 32'(gray_q), 32'(gray_tab[(k + 1) % 16]));
      check("up_wrap", 32'(wrap), 32'(k == 15));
      check("up_onebit", 32'($countones(gray_q ^ prev_gray)), 32'd1);
      prev_gray = gray_q;
    end

    // Load beats a simultaneous up-step.
    @(negedge clk);
    load = 1'b1;
    load_gray = 4'b1101;
    en = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #2;
    check("load_bin", 32'(bin_q), 32'd9);
    check("load_gray", 32'(gray_q), 32'b1101);

    // Count down from zero wraps to all ones.
    @(negedge clk);
    load = 1'b1;
    load_gray = 4'b0000;
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    en = 1'b1;
    up = 1'b0;
    #1;
    check("down_tc_pre", 32'(tc), 32'd1);
    @(posedge clk);
    #2;
    check("down_bin", 32'(bin_q), 32'd15);
    check("down_gray", 32'(gray_q), 32'b1000);
    check("down_wrap", 32'(wrap), 32'd1);
    @(posedge clk);
    #2;
    check("down2_bin", 32'(bin_q), 32'd14);
    check("down2_wrap", 32'(wrap), 32'd0);

    // Asynchronous reset in mid-count.
    @(negedge clk);
    en = 1'b0;
    load = 1'b1;
    load_gray = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    en = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #2;
    check("pre_rst_bin", 32'(bin_q), 32'd5);
    #1;
    rst = 1'b1;
    en = 1'b0;
    #1;
    check("async_rst_bin", 32'(bin_q), 32'd0);
    check("async_rst_gray", 32'(gray_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #2;
    check("post_rst_bin", 32'(bin_q), 32'd1);

    // Hold with toggling direction at zero: tc follows up.
    @(negedge clk);
    en = 1'b0;
    load = 1'b1;
    load_gray = 4'b0000;
    @(posedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      load = 1'b0;
      up = ~up;
      #1;
      check("hold_bin", 32'(bin_q), 32'd0);
      check("hold_gray", 32'(gray_q), 32'd0);
      check("hold_wrap", 32'(wrap), 32'd0);
      check("hold_tc", 32'(tc), 32'(!up));
    end

    // Load the terminal value, then step up.
    @(negedge clk);
    load = 1'b1;
    load_gray = 4'b1000;
    en = 1'b1;
    up = 1'b1;
    @(posedge clk);
    #2;
    check("term_load_bin", 32'(bin_q), 32'd15);
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #2;
`ifdef GRAY_CNT_SAT_EN
      check("sat_bin", 32'(bin_q), 32'd15);
      check("sat_gray", 32'(gray_q), 32'b1000);
      check("sat_flag", 32'(sat), 32'd1);
      check("sat_wrap", 32'(wrap), 32'd0);
`else
      check("term_bin", 32'(bin_q), 32'(k));
      check("term_wrap", 32'(wrap), 32'(k == 0));
`endif
    end

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
